// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage feeding the IF/ID pipeline register. It generates
//   the fetch PC and runs a req/ack handshake to instruction memory with one
//   request in flight. Returned words go into a small prefetch FIFO, and the
//   FIFO head is presented downstream. Downstream stall and redirect (flush)
//   are supported.
//
// Parameters
//   RESET_PC    first fetch address after reset (word aligned)
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   stall_i      downstream cannot accept; FIFO head is held
//   flush_i      redirect: drop buffered and in-flight words, refetch at new_pc_i
//   new_pc_i     redirect target, sampled while flush_i=1
//   mem_req_o    instruction memory request (registered)
//   mem_addr_o   request address, word aligned, stable while mem_req_o=1
//   mem_ack_i    one-cycle ack; mem_rdata_i is valid in the same cycle
//   mem_rdata_i  instruction word
//   if_valid_o   if_pc_o/if_inst_o hold a real instruction
//   if_pc_o      PC of the FIFO head, 0 when empty
//   if_inst_o    instruction of the FIFO head, 0 (bubble) when empty
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   redirect_pc;
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [31:0]   inst_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop;

  // Low address bits of the redirect target are forced to zero.
  logic [1:0] unused_pc_lsbs;
  assign unused_pc_lsbs = new_pc_i[1:0];
  assign redirect_pc    = {new_pc_i[31:2], 2'b00};

  // Only an ack to a live (non-superseded) request delivers a word; acks in
  // IDLE and DRAIN never reach the FIFO.
  assign push       = (state == WAIT) && mem_ack_i && !flush_i;
  assign if_valid_o = (count != '0);
  assign pop        = if_valid_o && !stall_i && !flush_i;

  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    count_next = count;
    if (push) count_next = count_next + 1'b1;
    if (pop)  count_next = count_next - 1'b1;
  end

  assign if_pc_o   = if_valid_o ? pc_q[rd_ptr]   : '0;
  assign if_inst_o = if_valid_o ? inst_q[rd_ptr] : '0;

  // NOTE: the FIFO storage has no reset; validity is tracked by count and the
  // pointers, so resetting the array would only add fan-out on rst.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= mem_addr_o;
      inst_q[wr_ptr] <= mem_rdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Request FSM. A request is never withdrawn before its ack; a flush during
  // an outstanding request parks in DRAIN until the stale ack arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      if (flush_i) fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + 32'd4;

      unique case (state)
        IDLE: begin
          if (flush_i) begin
            state      <= WAIT;
            mem_req_o  <= 1'b1;
            mem_addr_o <= redirect_pc;
          end else if (count < DEPTH_C) begin
            state      <= WAIT;
            mem_req_o  <= 1'b1;
            mem_addr_o <= fetch_pc;
          end
        end
        WAIT: begin
          if (flush_i) begin
            if (mem_ack_i) mem_addr_o <= redirect_pc;
            else           state      <= DRAIN;
          end else if (mem_ack_i) begin
            // count_next already accounts for this push, so a new request
            // only goes out when its return word is guaranteed a slot.
            if (count_next < DEPTH_C) begin
              mem_addr_o <= fetch_pc + 32'd4;
            end else begin
              state     <= IDLE;
              mem_req_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (mem_ack_i) begin
            state      <= WAIT;
            mem_addr_o <= flush_i ? redirect_pc : fetch_pc;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//   Self-checking bench for if_fetch. A transaction-level reference model
//   (an outstanding-request record plus a queue of {pc, inst} entries) is
//   stepped every cycle and compared with all DUT outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .new_pc_i   (new_pc_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .if_valid_o (if_valid_o),
    .if_pc_o    (if_pc_o),
    .if_inst_o  (if_inst_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one outstanding request (live or superseded by a
  // redirect), the next address to fetch, and the prefetched instructions.
  bit          m_req;
  bit          m_stale;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  task automatic model_step();
    int          size_before;
    bit          deliver, consume;
    logic [31:0] target;
    size_before = m_q.size();
    if (rst) begin
      m_req = 0; m_stale = 0; m_addr = '0; m_pc = RESET_PC;
      m_q.delete();
      return;
    end
    target  = new_pc_i & 32'hFFFF_FFFC;
    deliver = m_req && !m_stale && mem_ack_i && !flush_i;
    consume = (size_before > 0) && !stall_i && !flush_i;
    if (flush_i) begin
      m_q.delete();
      m_pc = target;
    end else begin
      if (consume) void'(m_q.pop_front());
      if (deliver) begin
        m_q.push_back({m_addr, mem_rdata_i});
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_req && !mem_ack_i) begin
      if (flush_i) m_stale = 1;                 // keep waiting for the old ack
    end else if (flush_i) begin
      m_req = 1; m_stale = 0; m_addr = target;
    end else if (!m_req) begin
      if (size_before < DEPTH) begin m_req = 1; m_addr = m_pc; end
    end else if (m_stale || m_q.size() < DEPTH) begin
      m_req = 1; m_stale = 0; m_addr = m_pc;
    end else begin
      m_req = 0;
    end
  endtask

  task automatic compare_outputs();
    check("mem_req",  {31'd0, mem_req_o},  {31'd0, m_req});
    check("mem_addr", mem_addr_o,          m_addr);
    check("if_valid", {31'd0, if_valid_o}, {31'd0, m_q.size() > 0});
    check("if_pc",    if_pc_o,   (m_q.size() > 0) ? m_q[0][63:32] : 32'h0);
    check("if_inst",  if_inst_o, (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0);
  endtask

  // One clock cycle: drive inputs, step the model at the edge, check on the
  // falling edge.
  task automatic cycle(input bit r, input bit s, input bit f,
                       input logic [31:0] np, input bit a);
    rst         = r;
    stall_i     = s;
    flush_i     = f;
    new_pc_i    = np;
    mem_ack_i   = a;
    mem_rdata_i = $urandom;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'hFFFF_FFF8;
      1:       t = 32'h0000_2002;
      2:       t = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      default: t = $urandom;
    endcase
    return t;
  endfunction

  initial begin
    // Reset, then continuous fetch with an always-ready memory.
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, 1);

    // Stall from reset: FIFO fills, requests stop, then drains and resumes.
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, '0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0, 1);

    // Flush while waiting, stale ack arrives three cycles later.
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 1, 32'h0000_2002, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, '0, 0);
    cycle(0, 0, 0, '0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);

    // Flush coincident with an ack.
    cycle(0, 0, 1, 32'h0000_3000, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1);

    // Redirect near the top of memory: addresses wrap to zero.
    cycle(0, 0, 1, 32'hFFFF_FFF8, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, '0, 1);

    // Reset mid-request with entries buffered.
    cycle(0, 1, 0, '0, 1);
    cycle(0, 1, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);

    // Randomized traffic: sparse acks (also while idle), stalls, redirects,
    // occasional resets.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0,
            pick_target(),
            $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
